lcd_bus_receiver: RTL and testbench
===================================

LCD_BUS_RECEIVER -- requirements
Module: lcd_bus_receiver

Interface
REQ-001 SHALL have parameter BUSY_CYCLES, default 40: busy duration, in clk cycles, after a data write or a non-clear command.
REQ-002 SHALL have parameter CLEAR_CYCLES, default 1600: total busy duration, in clk cycles, after clear (0x01) or home (0x02); minimum 32.
REQ-003 SHALL have port clk, input, 1: clock.
REQ-004 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have ports lcd_rs, lcd_rw, lcd_en, input, 1 each: HD44780-style bus strobes from the host, asynchronous to clk.
REQ-006 SHALL have ports lcd_data_in, input, 8: host write data; lcd_data_out, output, 8: read data; lcd_data_oe, output, 1: read-drive enable.
REQ-007 SHALL have port disp_addr, input, 5: display read index 0-31; disp_char, output, 8: combinational buffer[disp_addr].
REQ-008 SHALL have ports cursor, output, 5; busy, output, 1; disp_on, output, 1; cmd_err, output, 1 (1-cycle pulse); overrun, output, 1 (1-cycle pulse).

Function
REQ-009 SHALL hold a 32x8 character buffer: indices 0-15 = line 1, 16-31 = line 2.
REQ-010 SHALL synchronize lcd_en through two flops; a transaction SHALL be the registered falling edge of the synchronized en; lcd_rs, lcd_rw and lcd_data_in are sampled on that clk edge (host holds them stable across en low + 3 cycles).
REQ-011 SHALL apply a transaction's effect, including busy assertion, on the clk edge after the one that detects the falling edge.
REQ-012 SHALL implement FSM IDLE, CLEAR, BUSY; busy = (state != IDLE).
REQ-013 Data write (rs=1, rw=0) in IDLE SHALL write buffer[cursor] = data, step cursor by +1 (I/D=1) or -1 (I/D=0) with wrap 31->0 and 0->31, and enter BUSY for BUSY_CYCLES.
REQ-014 Command 0x01 SHALL set cursor=0 and I/D=1, then enter CLEAR, writing 0x20 to one index per cycle (0..31), then enter BUSY for CLEAR_CYCLES-32.
REQ-015 Command 0x02 SHALL set cursor=0 and enter BUSY for CLEAR_CYCLES; buffer unchanged.
REQ-016 Commands 0x04-0x07 SHALL set I/D = bit1; commands 0x08-0x0F SHALL set disp_on = bit2; each SHALL enter BUSY for BUSY_CYCLES.
REQ-017 Command 0x80|a SHALL set cursor = a for a in 0x00-0x0F, cursor = a-0x30 for a in 0x40-0x4F; any other a SHALL pulse cmd_err, leave cursor unchanged, and enter BUSY for BUSY_CYCLES.
REQ-018 Any other command byte SHALL have no effect except entering BUSY for BUSY_CYCLES.
REQ-019 A write transaction (rw=0) detected while busy SHALL be dropped with no state change and SHALL pulse overrun.
REQ-020 While synchronized en=1 and lcd_rw=1, lcd_data_oe SHALL be 1; with rs=0, lcd_data_out = {busy, 2'b00, cursor}; with rs=1, lcd_data_out = buffer[cursor].
REQ-021 A data-read transaction (rs=1, rw=1) in IDLE SHALL step cursor per I/D without entering BUSY; a status read (rs=0, rw=1) SHALL change no state and SHALL be legal while busy.
REQ-022 Busy counters SHALL count down to 1 and return to IDLE on the following edge; BUSY_CYCLES = N gives exactly N cycles of busy=1.

Reset
REQ-023 On reset, the block SHALL enter IDLE and set cursor=0, I/D=1, disp_on=0, busy=0, cmd_err=0, overrun=0, lcd_data_oe=0, lcd_data_out=0x00, and clear the en synchronizer to 0.
REQ-024 Reset SHALL fill the buffer with 0x20; reset during CLEAR or BUSY SHALL abort that operation immediately.

Configuration
REQ-025 With `LCD_RX_READ_EN` defined, the block SHALL support reads per REQ-020/REQ-021.
REQ-026 With `LCD_RX_READ_EN` undefined, lcd_data_oe and lcd_data_out SHALL be constant 0, and rw=1 transactions SHALL be ignored without pulsing cmd_err or overrun.

Verification
REQ-027 Reset, then write 0x48 ('H'), wait BUSY_CYCLES, write 0x52 -> buffer[0]=0x48, buffer[1]=0x52, cursor=2, busy high exactly 40 cycles after each write.
REQ-028 Send cmd 0xC5 -> cursor=21; send cmd 0x90 -> cmd_err pulse, cursor stays 21.
REQ-029 Send cmd 0x04 (I/D=0), set cursor 0, write 0x41 -> buffer[0]=0x41, cursor=31.
REQ-030 Fill the buffer, send cmd 0x01 -> all 32 entries 0x20 after 32 cycles, busy=1 for 1600 cycles, cursor=0.
REQ-031 Write data during busy -> overrun pulse, buffer unchanged; status read while busy -> lcd_data_out[7]=1.
REQ-032 Assert reset mid-CLEAR at sweep index 10 -> busy=0 on the next cycle and the entire buffer reads 0x20.

Source files
------------

// File: rtl/lcd_bus_receiver.sv
// HD44780-style write/read bus slave: 32-character buffer, cursor and busy timing.
// Optional read path (data_oe/data_out, rw=1 transactions) enabled by `LCD_RX_READ_EN.
module lcd_bus_receiver #(
  parameter int BUSY_CYCLES  = 40,
  parameter int CLEAR_CYCLES = 1600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  input  logic [4:0] disp_addr,
  output logic [7:0] disp_char,
  output logic [4:0] cursor,
  output logic       busy,
  output logic       disp_on,
  output logic       cmd_err,
  output logic       overrun
);

  localparam int CNT_MAX  = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int CLR_TAIL = CLEAR_CYCLES - 32;

`ifdef LCD_RX_READ_EN
  localparam logic READ_EN = 1'b1;
`else
  localparam logic READ_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_BUSY
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [4:0]       r_clr_idx;
  logic [4:0]       w_clr_idx_next;

  logic             r_en_s1;
  logic             r_en_s2;
  logic             r_en_s2_d;
  logic             r_txn;
  logic             r_rs;
  logic             r_rw;
  logic [7:0]       r_data;
  logic             w_en_fall;

  logic [4:0]       r_cursor;
  logic [4:0]       w_cursor_next;
  logic [4:0]       w_cursor_step;
  logic             r_id;
  logic             w_id_next;
  logic             r_disp_on;
  logic             w_disp_on_next;
  logic             r_cmd_err;
  logic             w_cmd_err_next;
  logic             r_overrun;
  logic             w_overrun_next;

  logic [7:0]       r_buf [32];
  logic             w_buf_we;
  logic [4:0]       w_buf_waddr;
  logic [7:0]       w_buf_wdata;

  // Two-flop synchronizer, then a delayed copy for falling-edge detection.
  assign w_en_fall = r_en_s2_d & ~r_en_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en_s1   <= 1'b0;
      r_en_s2   <= 1'b0;
      r_en_s2_d <= 1'b0;
      r_txn     <= 1'b0;
      r_rs      <= 1'b0;
      r_rw      <= 1'b0;
      r_data    <= 8'h00;
    end else begin
      r_en_s1   <= lcd_en;
      r_en_s2   <= r_en_s1;
      r_en_s2_d <= r_en_s2;
      r_txn     <= w_en_fall;
      if (w_en_fall) begin
        r_rs   <= lcd_rs;
        r_rw   <= lcd_rw;
        r_data <= lcd_data_in;
      end
    end
  end

  assign w_cursor_step = r_id ? (r_cursor + 5'd1) : (r_cursor - 5'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_clr_idx <= 5'd0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_clr_idx <= w_clr_idx_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_clr_idx_next = r_clr_idx;
    w_cursor_next  = r_cursor;
    w_id_next      = r_id;
    w_disp_on_next = r_disp_on;
    w_cmd_err_next = 1'b0;
    w_overrun_next = 1'b0;
    w_buf_we       = 1'b0;
    w_buf_waddr    = r_cursor;
    w_buf_wdata    = r_data;

    case (r_state)
      S_IDLE: begin
        if (r_txn && !r_rw) begin
          w_state_next = S_BUSY;
          w_cnt_next   = CNT_W'(BUSY_CYCLES);
          if (r_rs) begin
            w_buf_we      = 1'b1;
            w_cursor_next = w_cursor_step;
          end else if (r_data == 8'h01) begin
            w_cursor_next  = 5'd0;
            w_id_next      = 1'b1;
            w_state_next   = S_CLEAR;
            w_clr_idx_next = 5'd0;
          end else if (r_data == 8'h02) begin
            w_cursor_next = 5'd0;
            w_cnt_next    = CNT_W'(CLEAR_CYCLES);
          end else if (r_data[7:2] == 6'b000001) begin
            w_id_next = r_data[1];
          end else if (r_data[7:3] == 5'b00001) begin
            w_disp_on_next = r_data[2];
          end else if (r_data[7]) begin
            // Line 1 addresses 0x00-0x0F, line 2 addresses 0x40-0x4F.
            if (r_data[6:4] == 3'b000) begin
              w_cursor_next = {1'b0, r_data[3:0]};
            end else if (r_data[6:4] == 3'b100) begin
              w_cursor_next = {1'b1, r_data[3:0]};
            end else begin
              w_cmd_err_next = 1'b1;
            end
          end
        end else if (r_txn && r_rw && READ_EN && r_rs) begin
          w_cursor_next = w_cursor_step;
        end
      end
      S_CLEAR: begin
        w_buf_we       = 1'b1;
        w_buf_waddr    = r_clr_idx;
        w_buf_wdata    = 8'h20;
        w_clr_idx_next = r_clr_idx + 5'd1;
        if (r_clr_idx == 5'd31) begin
          if (CLR_TAIL == 0) begin
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_BUSY;
            w_cnt_next   = CNT_W'(CLR_TAIL);
          end
        end
      end
      S_BUSY: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    if (r_txn && !r_rw && (r_state != S_IDLE)) begin
      w_overrun_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cursor  <= 5'd0;
      r_id      <= 1'b1;
      r_disp_on <= 1'b0;
      r_cmd_err <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_cursor  <= w_cursor_next;
      r_id      <= w_id_next;
      r_disp_on <= w_disp_on_next;
      r_cmd_err <= w_cmd_err_next;
      r_overrun <= w_overrun_next;
    end
  end

  // Character buffer is flop-based: reset fills it and disp_char is a combinational read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_buf[i] <= 8'h20;
      end
    end else if (w_buf_we) begin
      r_buf[w_buf_waddr] <= w_buf_wdata;
    end
  end

  assign disp_char = r_buf[disp_addr];
  assign cursor    = r_cursor;
  assign busy      = (r_state != S_IDLE);
  assign disp_on   = r_disp_on;
  assign cmd_err   = r_cmd_err;
  assign overrun   = r_overrun;

`ifdef LCD_RX_READ_EN
  assign lcd_data_oe  = r_en_s2 & lcd_rw;
  assign lcd_data_out = !lcd_data_oe ? 8'h00 :
                        lcd_rs       ? r_buf[r_cursor] :
                                       {busy, 2'b00, r_cursor};
`else
  assign lcd_data_oe  = 1'b0;
  assign lcd_data_out = 8'h00;
`endif

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver: writes, commands, clear/home timing, overrun, reads, reset abort.
`timescale 1ns/1ps
module tb_lcd_bus_receiver;

  logic       clk;
  logic       reset;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic [7:0] lcd_data_in;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe;
  logic [4:0] disp_addr;
  logic [7:0] disp_char;
  logic [4:0] cursor;
  logic       busy;
  logic       disp_on;
  logic       cmd_err;
  logic       overrun;

  int n_checks = 0;
  int n_fails  = 0;
  int err_pulses = 0;
  int ovr_pulses = 0;

  lcd_bus_receiver #(
    .BUSY_CYCLES (40),
    .CLEAR_CYCLES(1600)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .lcd_rs      (lcd_rs),
    .lcd_rw      (lcd_rw),
    .lcd_en      (lcd_en),
    .lcd_data_in (lcd_data_in),
    .lcd_data_out(lcd_data_out),
    .lcd_data_oe (lcd_data_oe),
    .disp_addr   (disp_addr),
    .disp_char   (disp_char),
    .cursor      (cursor),
    .busy        (busy),
    .disp_on     (disp_on),
    .cmd_err     (cmd_err),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cmd_err === 1'b1) err_pulses++;
    if (overrun === 1'b1) ovr_pulses++;
  end

  task automatic peek(input int a, output logic [7:0] v);
    disp_addr = 5'(a);
    #1;
    v = disp_char;
  endtask

  task automatic bus_write(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs;
    lcd_rw = rw;
    lcd_data_in = d;
    lcd_en = 1'b1;
    repeat (3) @(negedge clk);
    lcd_en = 1'b0;
  endtask

  // Issues one write transaction and returns how many sampled cycles busy stayed high.
  task automatic txn_busy(input logic rs, input logic [7:0] d, output int dur);
    int lat;
    lat = 0;
    dur = 0;
    bus_write(rs, 1'b0, d);
    while (busy !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (busy !== 1'b1) begin
      n_checks++; n_fails++;
      $display("FAIL busy_rise: busy=%b after %0d cycles, required 1", busy, lat);
    end else begin
      while (busy === 1'b1 && dur < 5000) begin
        dur++;
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset;
    logic [7:0] v;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || cursor !== 5'd0 || disp_on !== 1'b0 || cmd_err !== 1'b0 || overrun !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_state: busy=%b cursor=%0d disp_on=%b cmd_err=%b overrun=%b, required 0 0 0 0 0",
               busy, cursor, disp_on, cmd_err, overrun);
    end
    n_checks++;
    if (lcd_data_oe !== 1'b0 || lcd_data_out !== 8'h00) begin
      n_fails++;
      $display("FAIL reset_bus: oe=%b data_out=%h, required 0 00", lcd_data_oe, lcd_data_out);
    end
    for (int i = 0; i < 32; i++) begin
      peek(i, v);
      n_checks++;
      if (v !== 8'h20) begin
        n_fails++;
        $display("FAIL reset_buf[%0d]: got %h, required 20", i, v);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_write;
    int d;
    logic [7:0] v;
    txn_busy(1'b1, 8'h48, d);
    n_checks++;
    if (d != 40) begin n_fails++; $display("FAIL write1_busy_len: got %0d, required 40", d); end
    txn_busy(1'b1, 8'h52, d);
    n_checks++;
    if (d != 40) begin n_fails++; $display("FAIL write2_busy_len: got %0d, required 40", d); end
    peek(0, v);
    n_checks++;
    if (v !== 8'h48) begin n_fails++; $display("FAIL write_buf0: got %h, required 48", v); end
    peek(1, v);
    n_checks++;
    if (v !== 8'h52) begin n_fails++; $display("FAIL write_buf1: got %h, required 52", v); end
    n_checks++;
    if (cursor !== 5'd2) begin n_fails++; $display("FAIL write_cursor: got %0d, required 2", cursor); end
    $display("test_write done: cursor=%0d", cursor);
  endtask

  task automatic test_cursor_cmd;
    int d;
    int e0;
    txn_busy(1'b0, 8'hC5, d);
    n_checks++;
    if (cursor !== 5'd21) begin n_fails++; $display("FAIL cmd_c5_cursor: got %0d, required 21", cursor); end
    e0 = err_pulses;
    txn_busy(1'b0, 8'h90, d);
    n_checks++;
    if (err_pulses - e0 != 1) begin n_fails++; $display("FAIL cmd_90_err_pulses: got %0d, required 1", err_pulses - e0); end
    n_checks++;
    if (cursor !== 5'd21) begin n_fails++; $display("FAIL cmd_90_cursor: got %0d, required 21", cursor); end
    n_checks++;
    if (d != 40) begin n_fails++; $display("FAIL cmd_90_busy_len: got %0d, required 40", d); end
    $display("test_cursor_cmd done: cursor=%0d", cursor);
  endtask

  task automatic test_id_dec;
    int d;
    logic [7:0] v;
    txn_busy(1'b0, 8'h04, d);
    txn_busy(1'b0, 8'h80, d);
    n_checks++;
    if (cursor !== 5'd0) begin n_fails++; $display("FAIL dec_setpos: got %0d, required 0", cursor); end
    txn_busy(1'b1, 8'h41, d);
    peek(0, v);
    n_checks++;
    if (v !== 8'h41) begin n_fails++; $display("FAIL dec_buf0: got %h, required 41", v); end
    n_checks++;
    if (cursor !== 5'd31) begin n_fails++; $display("FAIL dec_wrap_cursor: got %0d, required 31", cursor); end
    txn_busy(1'b0, 8'h06, d);
    $display("test_id_dec done");
  endtask

  task automatic test_disp;
    int d;
    txn_busy(1'b0, 8'h0C, d);
    n_checks++;
    if (disp_on !== 1'b1) begin n_fails++; $display("FAIL disp_on_0c: got %b, required 1", disp_on); end
    n_checks++;
    if (d != 40) begin n_fails++; $display("FAIL disp_busy_len: got %0d, required 40", d); end
    txn_busy(1'b0, 8'h08, d);
    n_checks++;
    if (disp_on !== 1'b0) begin n_fails++; $display("FAIL disp_on_08: got %b, required 0", disp_on); end
    $display("test_disp done");
  endtask

  task automatic test_clear;
    int d;
    int lat;
    logic [7:0] v;
    time t_r;
    time t_f;
    txn_busy(1'b0, 8'h80, d);
    for (int i = 0; i < 32; i++) txn_busy(1'b1, 8'(8'h40 + i), d);
    peek(5, v);
    n_checks++;
    if (v !== 8'h45) begin n_fails++; $display("FAIL fill_buf5: got %h, required 45", v); end
    n_checks++;
    if (cursor !== 5'd0) begin n_fails++; $display("FAIL fill_cursor_wrap: got %0d, required 0", cursor); end

    bus_write(1'b0, 1'b0, 8'h01);
    lat = 0;
    while (busy !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fails++;
      $display("FAIL clear_busy_rise: busy=%b, required 1", busy);
    end else begin
      t_r = $time;
      repeat (31) @(posedge clk);
      #1;
      peek(31, v);
      n_checks++;
      if (v !== 8'h5F) begin n_fails++; $display("FAIL clear_idx31_pending: got %h, required 5f", v); end
      @(posedge clk); #1;
      for (int i = 0; i < 32; i++) begin
        peek(i, v);
        n_checks++;
        if (v !== 8'h20) begin n_fails++; $display("FAIL clear_buf[%0d]: got %h, required 20", i, v); end
      end
      lat = 0;
      while (busy === 1'b1 && lat < 3000) begin @(posedge clk); #1; lat++; end
      t_f = $time;
      n_checks++;
      if ((t_f - t_r) / 10 != 1600) begin
        n_fails++;
        $display("FAIL clear_busy_len: got %0d, required 1600", (t_f - t_r) / 10);
      end
    end
    n_checks++;
    if (cursor !== 5'd0) begin n_fails++; $display("FAIL clear_cursor: got %0d, required 0", cursor); end
    $display("test_clear done");
  endtask

  task automatic test_overrun;
    int lat;
    int o0;
    logic [7:0] v;
    o0 = ovr_pulses;
    bus_write(1'b1, 1'b0, 8'h55);
    lat = 0;
    while (busy !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    n_checks++;
    if (busy !== 1'b1) begin n_fails++; $display("FAIL ovr_busy_rise: busy=%b, required 1", busy); end
    @(negedge clk);
    lcd_rs = 1'b0;
    lcd_rw = 1'b1;
    lcd_en = 1'b1;
    repeat (3) @(negedge clk);
`ifdef LCD_RX_READ_EN
    n_checks++;
    if (lcd_data_oe !== 1'b1 || lcd_data_out !== 8'h81) begin
      n_fails++;
      $display("FAIL status_while_busy: oe=%b data_out=%h, required 1 81", lcd_data_oe, lcd_data_out);
    end
`else
    n_checks++;
    if (lcd_data_oe !== 1'b0 || lcd_data_out !== 8'h00) begin
      n_fails++;
      $display("FAIL status_no_read: oe=%b data_out=%h, required 0 00", lcd_data_oe, lcd_data_out);
    end
`endif
    lcd_en = 1'b0;
    repeat (4) @(negedge clk);
    bus_write(1'b1, 1'b0, 8'h66);
    lat = 0;
    while (busy === 1'b1 && lat < 200) begin @(posedge clk); #1; lat++; end
    n_checks++;
    if (ovr_pulses - o0 != 1) begin n_fails++; $display("FAIL ovr_pulses: got %0d, required 1", ovr_pulses - o0); end
    n_checks++;
    if (cursor !== 5'd1) begin n_fails++; $display("FAIL ovr_cursor: got %0d, required 1", cursor); end
    peek(0, v);
    n_checks++;
    if (v !== 8'h55) begin n_fails++; $display("FAIL ovr_buf0: got %h, required 55", v); end
    peek(1, v);
    n_checks++;
    if (v !== 8'h20) begin n_fails++; $display("FAIL ovr_buf1: got %h, required 20", v); end
    $display("test_overrun done");
  endtask

  task automatic test_read;
    int d;
    int e0;
    int o0;
    txn_busy(1'b0, 8'h80, d);
    e0 = err_pulses;
    o0 = ovr_pulses;
    @(negedge clk);
    lcd_rs = 1'b1;
    lcd_rw = 1'b1;
    lcd_en = 1'b1;
    repeat (3) @(negedge clk);
`ifdef LCD_RX_READ_EN
    n_checks++;
    if (lcd_data_oe !== 1'b1 || lcd_data_out !== 8'h55) begin
      n_fails++;
      $display("FAIL data_read: oe=%b data_out=%h, required 1 55", lcd_data_oe, lcd_data_out);
    end
`else
    n_checks++;
    if (lcd_data_oe !== 1'b0 || lcd_data_out !== 8'h00) begin
      n_fails++;
      $display("FAIL data_read_disabled: oe=%b data_out=%h, required 0 00", lcd_data_oe, lcd_data_out);
    end
`endif
    lcd_en = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fails++; $display("FAIL read_busy: got %b, required 0", busy); end
`ifdef LCD_RX_READ_EN
    n_checks++;
    if (cursor !== 5'd1) begin n_fails++; $display("FAIL read_cursor_step: got %0d, required 1", cursor); end
`else
    n_checks++;
    if (cursor !== 5'd0) begin n_fails++; $display("FAIL read_cursor_ignored: got %0d, required 0", cursor); end
`endif
    n_checks++;
    if (err_pulses != e0 || ovr_pulses != o0) begin
      n_fails++;
      $display("FAIL read_pulses: err=%0d ovr=%0d, required 0 0", err_pulses - e0, ovr_pulses - o0);
    end
    $display("test_read done: cursor=%0d", cursor);
  endtask

  task automatic test_home;
    int d;
    logic [7:0] v;
    txn_busy(1'b0, 8'hCF, d);
    n_checks++;
    if (cursor !== 5'd31) begin n_fails++; $display("FAIL cmd_cf_cursor: got %0d, required 31", cursor); end
    txn_busy(1'b1, 8'h5A, d);
    n_checks++;
    if (cursor !== 5'd0) begin n_fails++; $display("FAIL inc_wrap_cursor: got %0d, required 0", cursor); end
    txn_busy(1'b0, 8'hC3, d);
    n_checks++;
    if (cursor !== 5'd19) begin n_fails++; $display("FAIL cmd_c3_cursor: got %0d, required 19", cursor); end
    txn_busy(1'b0, 8'h02, d);
    n_checks++;
    if (d != 1600) begin n_fails++; $display("FAIL home_busy_len: got %0d, required 1600", d); end
    n_checks++;
    if (cursor !== 5'd0) begin n_fails++; $display("FAIL home_cursor: got %0d, required 0", cursor); end
    peek(31, v);
    n_checks++;
    if (v !== 8'h5A) begin n_fails++; $display("FAIL home_buf31: got %h, required 5a", v); end
    $display("test_home done");
  endtask

  task automatic test_reset_mid_clear;
    int lat;
    logic [7:0] v;
    bus_write(1'b0, 1'b0, 8'h01);
    lat = 0;
    while (busy !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    repeat (10) @(posedge clk);
    #1;
    peek(31, v);
    n_checks++;
    if (v !== 8'h5A || busy !== 1'b1) begin
      n_fails++;
      $display("FAIL midclear_pre: buf31=%h busy=%b, required 5a 1", v, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || cursor !== 5'd0) begin
      n_fails++;
      $display("FAIL midclear_abort: busy=%b cursor=%0d, required 0 0", busy, cursor);
    end
    for (int i = 0; i < 32; i++) begin
      peek(i, v);
      n_checks++;
      if (v !== 8'h20) begin n_fails++; $display("FAIL midclear_buf[%0d]: got %h, required 20", i, v); end
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fails++; $display("FAIL midclear_after: busy=%b, required 0", busy); end
    $display("test_reset_mid_clear done");
  endtask

  initial begin
    reset = 1'b1;
    lcd_rs = 1'b0;
    lcd_rw = 1'b0;
    lcd_en = 1'b0;
    lcd_data_in = 8'h00;
    disp_addr = 5'd0;
    test_reset();
    test_write();
    test_cursor_cmd();
    test_id_dec();
    test_disp();
    test_clear();
    test_overrun();
    test_read();
    test_home();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
